// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges hazard/flush requests into stall_o and sequences the divider.
// Latency: stall/flush/divider strobes are combinational; FSM state and counters update next cycle.
// Backpressure: holds PC..EX/MEM while a divide runs; a timeout releases the pipeline.
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             div_req_i,
  input  logic             div_ready_i,
  input  logic             flush_req_i,
  input  logic [31:0]      flush_pc_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_done_o,
  output logic             div_err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_div_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_div_hold;
  logic w_tmo_hit;

  // The divide holds EX from the request cycle until the result is accepted.
  assign w_div_hold = (r_state == DIV_BUSY) || ((r_state == IDLE) && div_req_i);
  assign w_tmo_hit  = (r_tmo_cnt == TW'(DIV_TIMEOUT - 1));

  // Priority-encode stall/flush and derive the divider handshake strobes.
  always_comb begin
    stall_o     = 6'b000000;
    flush_o     = 1'b0;
    new_pc_o    = 32'h0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    div_done_o  = 1'b0;
    if (!rst) begin
      if (flush_req_i) begin
        flush_o  = 1'b1;
        new_pc_o = flush_pc_i;
      end else if (w_div_hold || stallreq_ex_i) begin
        stall_o = 6'b001111;
      end else if (stallreq_id_i) begin
        stall_o = 6'b000111;
      end
      // A flushed instruction must never launch a divide.
      div_start_o = (r_state == IDLE) && div_req_i && !flush_req_i;
      // Abort on flush, or when the divider has run out of time without answering.
      div_annul_o = (r_state == DIV_BUSY) &&
                    (flush_req_i || (!div_ready_i && w_tmo_hit));
      div_done_o  = (r_state == DIV_DONE);
    end
  end

  // Divider sequencer with timeout counter and sticky timeout error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tmo_cnt <= '0;
      r_div_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_req_i && !flush_req_i) begin
            r_state   <= DIV_BUSY;
            r_tmo_cnt <= '0;
          end
        end
        DIV_BUSY: begin
          if (flush_req_i) begin
            r_state <= IDLE;
          end else if (div_ready_i) begin
            r_state <= DIV_DONE;
          end else if (w_tmo_hit) begin
            r_state   <= DIV_DONE;
            r_div_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        DIV_DONE: begin
          // Always pass through IDLE so the same instruction cannot re-trigger.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign div_err_o      = r_div_err;
  assign stall_cycles_o = r_stall_cnt;

endmodule
